sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO. It generalises the team's async FIFO flag set (full, empty, half_full, half_empty) with programmable almost-full/almost-empty thresholds, sticky and pulsed error reporting, and an occupancy count. It is used wherever producer and consumer share a clock. It exposes the same signal names the FIFO monitor class already samples, so the existing env can observe it.

Parameters:
DATA_WIDTH, 8, data word width in bits.
DEPTH, 16, number of entries; power of 2 and >= 4.
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH-1.
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 1..DEPTH-1.

Ports:
clk  input  1  single clock; all logic on posedge.
rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
w_en  input  1  write request.
data_in  input  DATA_WIDTH  write data, sampled when a write is accepted.
r_en  input  1  read request.
data_out  output  DATA_WIDTH  read data, registered.
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
half_full  output  1  count >= DEPTH/2.
half_empty  output  1  count <= DEPTH/2.
almost_full  output  1  count >= AF_THRESH.
almost_empty  output  1  count <= AE_THRESH.
write_error  output  1  one-cycle pulse: write rejected.
read_error  output  1  one-cycle pulse: read rejected.
overflow_sticky  output  1  set by any write_error; cleared only by reset.
underflow_sticky  output  1  set by any read_error; cleared only by reset.

Behaviour:
- Reset values: count=0, empty=1, half_empty=1, almost_empty=1. full, half_full, almost_full, write_error, read_error, both sticky flags and data_out are all 0. Pointers are 0. Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits wide. The low bits address memory; the MSB is the wrap bit. They increment modulo 2*DEPTH. count is a separate register.
- Write accepted when w_en && (!full || r_en_accepted). data_in is stored at wr_ptr and wr_ptr increments at the same posedge.
- Read accepted when r_en && !empty. mem[rd_ptr] is registered into data_out at that posedge, so data appears 1 cycle after r_en. rd_ptr increments. data_out holds its value when no read is accepted.
- Simultaneous read and write when full: both are accepted, count is unchanged, no error.
- Simultaneous read and write when empty: the read is rejected (read_error pulse), the write is accepted, count goes to 1. There is no fall-through.
- Simultaneous read and write at other occupancies: both are accepted, count is unchanged.
- count: +1 on write-only accept, -1 on read-only accept, unchanged otherwise.
- All status flags decode combinationally from the registered count. They are valid in the cycle after the causing edge and are glitch-free relative to clk.
- write_error: registered, high for exactly the 1 cycle after a posedge where w_en=1 and the write was rejected. Memory, wr_ptr and count are untouched.
- read_error: same rule for a rejected r_en. data_out keeps its previous value.
- Back-to-back rejected requests give one pulse per rejected cycle.
- Wrap-around: after 2*DEPTH accepted writes, wr_ptr returns to 0. Occupancy stays correct across any number of wraps.
- Reset mid-operation: all state returns to reset values asynchronously. Any in-flight read result is discarded.
- Parameter checks: elaboration-time assertions enforce DEPTH a power of 2 and >= 4, and AF_THRESH and AE_THRESH within 1..DEPTH-1.

Decomposition:
- Package fifo_pkg:
  - function clog2-based width constants: ADDR_W(DEPTH), CNT_W(DEPTH).
  - typedef struct packed fifo_flags_t {full, empty, half_full, half_empty, almost_full, almost_empty}, for the monitor and scoreboard to reuse.
- Sub-module fifo_mem: dual-port register array, 1 write port and 1 registered read port, parameterised on DATA_WIDTH and DEPTH, no reset.
- Top level holds the pointers, count, flag decode and error logic.

Test Plan:
- Reset then idle, DEPTH=16 -> count=0, empty=1, half_empty=1, almost_empty=1, all other outputs 0.
- Write 0x01..0x10 (16 writes), then read 16 -> full=1 after the 16th write. data_out sequence is 0x01..0x10, each 1 cycle after its r_en. empty=1 at the end.
- Write when full (count=16, w_en=1, r_en=0) -> write_error high for exactly 1 cycle, overflow_sticky=1, count stays 16, next read returns 0x01.
- Read when empty with simultaneous w_en, data_in=0xA5 -> read_error 1-cycle pulse, underflow_sticky=1, count=1, next read returns 0xA5.
- Threshold sweep, AF_THRESH=14, AE_THRESH=2 -> almost_empty drops at count=3; half_full rises at count=8; half_empty drops at count=9; almost_full rises at count=14.
- 40 cycles of random simultaneous w_en/r_en with rst_n pulsed low at cycle 25 -> scoreboard data matches; all outputs return to reset values in the cycle rst_n falls; correct behaviour across pointer wrap.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared width helpers and flag bundle for the single-clock FIFO
package fifo_pkg;

    function automatic int ADDR_W(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int CNT_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic half_full;
        logic half_empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - register array with one write port and one registered read port
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [ADDR_W(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    input  logic [ADDR_W(DEPTH)-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]      rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy count, threshold flags and error reporting
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_en,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      r_en,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [CNT_W(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty,
    output logic                      half_full,
    output logic                      half_empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      write_error,
    output logic                      read_error,
    output logic                      overflow_sticky,
    output logic                      underflow_sticky
);

    localparam int AW = ADDR_W(DEPTH);
    localparam int CW = CNT_W(DEPTH);

    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_HALF  = CW'(DEPTH / 2);
    localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be a power of 2 and >= 4");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH - 1)) begin : g_bad_af
        $error("sync_fifo_flags: AF_THRESH must be within 1..DEPTH-1");
    end
    if ((AE_THRESH < 1) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_flags: AE_THRESH must be within 1..DEPTH-1");
    end

    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  rd_seen;
    logic [DATA_WIDTH-1:0] mem_q;

    assign full         = (count == C_DEPTH);
    assign empty        = (count == '0);
    assign half_full    = (count >= C_HALF);
    assign half_empty   = (count <= C_HALF);
    assign almost_full  = (count >= C_AF);
    assign almost_empty = (count <= C_AE);

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
    assign rd_acc = r_en && !empty;
    assign wr_acc = w_en && (!full || rd_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            write_error      <= 1'b0;
            read_error       <= 1'b0;
            overflow_sticky  <= 1'b0;
            underflow_sticky <= 1'b0;
            rd_seen          <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + C_ONE;
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + C_ONE;
                rd_seen <= 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + C_ONE;
                2'b01:   count <= count - C_ONE;
                default: count <= count;
            endcase
            write_error <= w_en && !wr_acc;
            read_error  <= r_en && !rd_acc;
            if (w_en && !wr_acc) begin
                overflow_sticky <= 1'b1;
            end
            if (r_en && !rd_acc) begin
                underflow_sticky <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (mem_q)
    );

    // The array has no reset; until a read lands after reset the output is forced to zero.
    assign data_out = rd_seen ? mem_q : '0;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - scoreboard bench for sync_fifo_flags against a queue model
module tb_sync_fifo_flags;
    import fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic [4:0]    count;
    logic full, empty, half_full, half_empty, almost_full, almost_empty;
    logic write_error, read_error, overflow_sticky, underflow_sticky;

    sync_fifo_flags #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .w_en             (w_en),
        .data_in          (data_in),
        .r_en             (r_en),
        .data_out         (data_out),
        .count            (count),
        .full             (full),
        .empty            (empty),
        .half_full        (half_full),
        .half_empty       (half_empty),
        .almost_full      (almost_full),
        .almost_empty     (almost_empty),
        .write_error      (write_error),
        .read_error       (read_error),
        .overflow_sticky  (overflow_sticky),
        .underflow_sticky (underflow_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cnt;
        fifo_flags_t fl;
        logic        we;
        logic        re;
        logic        ovf;
        logic        unf;
        logic [DW-1:0] dout;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] model_q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [DW-1:0] m_dout = '0;
    int            checks = 0;
    int            errors = 0;
    fifo_flags_t   act_fl;

    assign act_fl = '{full, empty, half_full, half_empty, almost_full, almost_empty};

    function automatic fifo_flags_t flags_of(input int n);
        fifo_flags_t f;
        f.full         = (n == DEPTH);
        f.empty        = (n == 0);
        f.half_full    = (n >= DEPTH / 2);
        f.half_empty   = (n <= DEPTH / 2);
        f.almost_full  = (n >= AF);
        f.almost_empty = (n <= AE);
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: one cycle of requests applied to a plain queue.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
        exp_t e;
        logic rd_ok, wr_ok;
        @(negedge clk);
        w_en = w;
        r_en = r;
        data_in = d;
        rd_ok = r && (model_q.size() > 0);
        wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
        if (rd_ok) m_dout = model_q.pop_front();
        if (wr_ok) model_q.push_back(d);
        if (w && !wr_ok) m_ovf = 1'b1;
        if (r && !rd_ok) m_unf = 1'b1;
        e.cnt  = model_q.size();
        e.fl   = flags_of(e.cnt);
        e.we   = w && !wr_ok;
        e.re   = r && !rd_ok;
        e.ovf  = m_ovf;
        e.unf  = m_unf;
        e.dout = m_dout;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        w_en = 1'b0;
        r_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_flags", 32'(act_fl), 32'(flags_of(0)));
        chk("rst_write_error", 32'(write_error), 32'd0);
        chk("rst_read_error", 32'(read_error), 32'd0);
        chk("rst_overflow_sticky", 32'(overflow_sticky), 32'd0);
        chk("rst_underflow_sticky", 32'(underflow_sticky), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_dout = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("count", 32'(count), 32'(e.cnt));
                chk("flags", 32'(act_fl), 32'(e.fl));
                chk("write_error", 32'(write_error), 32'(e.we));
                chk("read_error", 32'(read_error), 32'(e.re));
                chk("overflow_sticky", 32'(overflow_sticky), 32'(e.ovf));
                chk("underflow_sticky", 32'(underflow_sticky), 32'(e.unf));
                chk("data_out", 32'(data_out), 32'(e.dout));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        do_reset();
        cycle(1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 8'(i));
        cycle(1'b1, 1'b0, 8'hEE);
        cycle(1'b1, 1'b0, 8'hEF);
        cycle(1'b1, 1'b1, 8'h77);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 8'hA5);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 40; i++) begin
            if (i == 25) do_reset();
            else cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 4), 8'($urandom));
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 6), 8'($urandom));
        cycle(1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
